// File: rtl/hailstone_engine.sv
// Collatz (hailstone) sequence generator: walks a start value down to 1, streaming each term over valid/ready.
// Optional macro HAILSTONE_SHORTCUT_EN folds an odd step and the following halving into one handshake.
module hailstone_engine #(
   parameter int WIDTH     = 16,
   parameter int CNT_WIDTH = 16,
   parameter int MAX_STEPS = 1000
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     n_in,
   output logic                 busy,
   output logic                 done,
   output logic [WIDTH-1:0]     term,
   output logic                 term_valid,
   input  logic                 term_ready,
   output logic [CNT_WIDTH-1:0] steps,
   output logic [WIDTH-1:0]     peak,
   output logic                 err_zero,
   output logic                 err_overflow,
   output logic                 err_limit
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int NW = WIDTH + 2;

   state_t               state;
   logic [NW-1:0]        cur_x;
   logic [NW-1:0]        triple;
   logic [NW-1:0]        next_val;
   logic [WIDTH-1:0]     next_term;
   logic [CNT_WIDTH-1:0] step_inc;
   logic                 hit_limit;
   logic                 too_big;
   logic                 handshake;

`ifdef HAILSTONE_SHORTCUT_EN
   logic [CNT_WIDTH:0]   steps_x;
`endif

   // The current term lives in the term register itself; next-term math is widened
   // by two bits so 3*cur+1 never wraps before the overflow test.
   always_comb begin
      cur_x     = NW'(term);
      triple    = (cur_x << 1) + cur_x + NW'(1);
`ifdef HAILSTONE_SHORTCUT_EN
      steps_x   = {1'b0, steps};
      if (term[0]) begin
         next_val  = triple >> 1;
         step_inc  = CNT_WIDTH'(2);
         hit_limit = (steps_x + (CNT_WIDTH+1)'(2)) > (CNT_WIDTH+1)'(MAX_STEPS);
      end else begin
         next_val  = cur_x >> 1;
         step_inc  = CNT_WIDTH'(1);
         hit_limit = (steps == CNT_WIDTH'(MAX_STEPS));
      end
`else
      next_val  = term[0] ? triple : (cur_x >> 1);
      step_inc  = CNT_WIDTH'(1);
      hit_limit = (steps == CNT_WIDTH'(MAX_STEPS));
`endif
      too_big   = |next_val[NW-1:WIDTH];
      next_term = next_val[WIDTH-1:0];
      handshake = term_valid & term_ready;
   end

   // Control FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         term         <= '0;
         term_valid   <= 1'b0;
         steps        <= '0;
         peak         <= '0;
         err_zero     <= 1'b0;
         err_overflow <= 1'b0;
         err_limit    <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  term         <= n_in;
                  steps        <= '0;
                  peak         <= n_in;
                  done         <= 1'b0;
                  err_zero     <= 1'b0;
                  err_overflow <= 1'b0;
                  err_limit    <= 1'b0;
                  if (n_in == '0) begin
                     state    <= DONE;
                     done     <= 1'b1;
                     err_zero <= 1'b1;
                  end else begin
                     state      <= RUN;
                     busy       <= 1'b1;
                     term_valid <= 1'b1;
                  end
               end
            end
            RUN: begin
               if (handshake) begin
                  if (term == WIDTH'(1) || hit_limit || too_big) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     done       <= 1'b1;
                     term_valid <= 1'b0;
                     // Priority: reaching 1 beats the limit, which beats overflow.
                     if (term != WIDTH'(1)) begin
                        if (hit_limit) err_limit    <= 1'b1;
                        else           err_overflow <= 1'b1;
                     end
                  end else begin
                     term  <= next_term;
                     steps <= steps + step_inc;
                     if (next_term > peak) peak <= next_term;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hailstone_engine.sv
// Scoreboard bench for hailstone_engine: three instances (default, WIDTH=8, MAX_STEPS=5)
// checked against a behavioural Collatz model; honours HAILSTONE_SHORTCUT_EN.
module tb_hailstone_engine;

   localparam int CW    = 16;
   localparam int MAXD  = 1000;
   localparam int MAXL  = 5;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic        start_v [3];
   logic        ready_v [3];
   logic [15:0] n_v     [3];
   logic        busy_v  [3];
   logic        done_v  [3];
   logic        tv_v    [3];
   logic        ez_v    [3];
   logic        eo_v    [3];
   logic        el_v    [3];
   logic [15:0] term_v  [3];
   logic [15:0] peak_v  [3];
   logic [15:0] steps_v [3];
   logic [7:0]  term8, peak8;

   int vectors = 0;
   int miscompares = 0;

   longint exp_q[$];
   longint exp_steps, exp_peak;
   int     exp_err;
   int     width_of [3] = '{16, 8, 16};
   int     max_of   [3] = '{MAXD, MAXD, MAXL};

   initial assert (MAXD < (1 << CW) && MAXL < (1 << CW))
      else $fatal(1, "[TB] MAX_STEPS must be below 2**CNT_WIDTH");

   hailstone_engine #(.WIDTH(16), .CNT_WIDTH(CW), .MAX_STEPS(MAXD)) dut0 (
      .clk(clk), .reset(reset), .start(start_v[0]), .n_in(n_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .term(term_v[0]), .term_valid(tv_v[0]),
      .term_ready(ready_v[0]), .steps(steps_v[0]), .peak(peak_v[0]),
      .err_zero(ez_v[0]), .err_overflow(eo_v[0]), .err_limit(el_v[0]));

   hailstone_engine #(.WIDTH(8), .CNT_WIDTH(CW), .MAX_STEPS(MAXD)) dut1 (
      .clk(clk), .reset(reset), .start(start_v[1]), .n_in(n_v[1][7:0]),
      .busy(busy_v[1]), .done(done_v[1]), .term(term8), .term_valid(tv_v[1]),
      .term_ready(ready_v[1]), .steps(steps_v[1]), .peak(peak8),
      .err_zero(ez_v[1]), .err_overflow(eo_v[1]), .err_limit(el_v[1]));

   hailstone_engine #(.WIDTH(16), .CNT_WIDTH(CW), .MAX_STEPS(MAXL)) dut2 (
      .clk(clk), .reset(reset), .start(start_v[2]), .n_in(n_v[2]),
      .busy(busy_v[2]), .done(done_v[2]), .term(term_v[2]), .term_valid(tv_v[2]),
      .term_ready(ready_v[2]), .steps(steps_v[2]), .peak(peak_v[2]),
      .err_zero(ez_v[2]), .err_overflow(eo_v[2]), .err_limit(el_v[2]));

   assign term_v[1] = {8'h00, term8};
   assign peak_v[1] = {8'h00, peak8};

   task automatic checkOutput(input string tag, input longint obs, input longint exp);
      vectors++;
      if (obs !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // Reference walk of the sequence; err codes 0 none, 1 zero, 2 overflow, 3 limit.
   function automatic void model(input longint n, input int width, input int maxs);
      longint cur, nxt, lim;
      int inc;
      exp_q.delete();
      exp_steps = 0;
      exp_err   = 0;
      exp_peak  = n;
      lim = (longint'(1) << width) - 1;
      if (n == 0) begin
         exp_err = 1;
         return;
      end
      cur = n;
      for (int guard = 0; guard < 5000; guard++) begin
         exp_q.push_back(cur);
         if (cur == 1) return;
`ifdef HAILSTONE_SHORTCUT_EN
         if (cur % 2 == 1) begin
            if (exp_steps + 2 > maxs) begin exp_err = 3; return; end
            nxt = (3 * cur + 1) / 2;
            inc = 2;
         end else begin
            if (exp_steps == maxs) begin exp_err = 3; return; end
            nxt = cur / 2;
            inc = 1;
         end
`else
         if (exp_steps == maxs) begin exp_err = 3; return; end
         nxt = (cur % 2 == 1) ? 3 * cur + 1 : cur / 2;
         inc = 1;
`endif
         if (nxt > lim) begin exp_err = 2; return; end
         cur = nxt;
         exp_steps += inc;
         if (nxt > exp_peak) exp_peak = nxt;
      end
   endfunction

   task automatic checkIdle(input int idx, input string tag);
      checkOutput({tag, "_busy"},  busy_v[idx],  0);
      checkOutput({tag, "_done"},  done_v[idx],  0);
      checkOutput({tag, "_valid"}, tv_v[idx],    0);
      checkOutput({tag, "_term"},  term_v[idx],  0);
      checkOutput({tag, "_steps"}, steps_v[idx], 0);
      checkOutput({tag, "_peak"},  peak_v[idx],  0);
      checkOutput({tag, "_errs"},  {ez_v[idx], eo_v[idx], el_v[idx]}, 0);
   endtask

   // mode 0: ready held high; mode 1: ready pattern 1,0,0 repeating.
   // pulse: drive spurious starts during the run; abort_at: reset after that many handshakes.
   task automatic applyStimulus(input int idx, input int n, input int mode,
                                input bit pulse, input int abort_at);
      int hs = 0;
      bit finished = 0;
      bit aborted = 0;
      longint last = n;
      model(n, width_of[idx], max_of[idx]);
      start_v[idx] = 1'b1;
      n_v[idx]     = 16'(n);
      @(posedge clk); #1;
      start_v[idx] = 1'b0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         ready_v[idx] = (mode == 0) ? 1'b1 : (cyc % 3 == 0);
         if (pulse) begin
            start_v[idx] = (cyc % 4 == 2);
            n_v[idx]     = 16'd99;
         end
         @(negedge clk);
         if (cyc == 0) checkOutput("latency_valid", tv_v[idx], (n != 0));
         if (done_v[idx]) begin
            start_v[idx] = 1'b0;
            finished = 1;
            break;
         end
         if (mode == 0) checkOutput("throughput_valid", tv_v[idx], 1);
         if (tv_v[idx] && ready_v[idx]) begin
            if (exp_q.size() == 0) checkOutput("extra_term", term_v[idx], -1);
            else begin
               last = exp_q.pop_front();
               checkOutput("term", term_v[idx], last);
            end
            hs++;
         end else if (tv_v[idx] && exp_q.size() != 0) begin
            checkOutput("stall_term", term_v[idx], exp_q[0]);
         end
         @(posedge clk); #1;
         if (abort_at != 0 && hs == abort_at) begin
            aborted = 1;
            break;
         end
      end
      start_v[idx] = 1'b0;
      if (aborted) begin
         reset = 1'b1;
         @(posedge clk); #1;
         reset = 1'b0;
         ready_v[idx] = 1'b0;
         @(negedge clk);
         checkIdle(idx, "midrun_reset");
         exp_q.delete();
         @(posedge clk); #1;
         return;
      end
      if (!finished) begin
         checkOutput("timeout", 0, 1);
         return;
      end
      checkOutput("terms_left", exp_q.size(), 0);
      checkOutput("steps", steps_v[idx], exp_steps);
      checkOutput("peak", peak_v[idx], exp_peak);
      checkOutput("err_zero", ez_v[idx], exp_err == 1);
      checkOutput("err_overflow", eo_v[idx], exp_err == 2);
      checkOutput("err_limit", el_v[idx], exp_err == 3);
      checkOutput("end_busy", busy_v[idx], 0);
      checkOutput("end_valid", tv_v[idx], 0);
      checkOutput("end_term_hold", term_v[idx], last);
      @(posedge clk); #1;
      ready_v[idx] = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         ready_v[i] = 1'b0;
         n_v[i]     = '0;
      end
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 3; i++) checkIdle(i, "reset");
      @(posedge clk); #1;

      applyStimulus(0, 6, 0, 0, 0);
      applyStimulus(0, 27, 0, 0, 0);
      applyStimulus(0, 7, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0);
      applyStimulus(0, 1, 0, 0, 0);
      applyStimulus(1, 255, 0, 0, 0);
      applyStimulus(2, 7, 0, 0, 0);
      applyStimulus(0, 27, 0, 0, 3);
      applyStimulus(0, 6, 0, 0, 0);
      applyStimulus(0, 27, 1, 1, 0);
      applyStimulus(1, 7, 1, 0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/hailstone_engine.md
Name: hailstone_engine

Overview:
- Parametrised hardware Collatz (hailstone) sequence generator for the microcpu system.
- Takes a start value, walks the sequence to 1, and streams every term over a valid/ready port.
- Reports the step count, the peak term and error flags.
- Replaces the software hailstone loop (LSR/AND/ADD/BNZ); width and step limit are configurable.

Parameters:
- WIDTH, 16: term width in bits.
- CNT_WIDTH, 16: width of the steps counter.
- MAX_STEPS, 1000: step limit; the run aborts with err_limit if it is reached before the sequence hits 1.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request a new run; sampled only when not busy.
- n_in  in  WIDTH  start value; captured on an accepted start.
- busy  out  1  high while a run is in progress.
- done  out  1  high from run end until the next accepted start.
- term  out  WIDTH  current sequence term.
- term_valid  out  1  term is valid.
- term_ready  in  1  consumer accepts term.
- steps  out  CNT_WIDTH  transitions applied so far.
- peak  out  WIDTH  maximum emitted term.
- err_zero  out  1  the run was started with n_in==0.
- err_overflow  out  1  the next term did not fit in WIDTH bits.
- err_limit  out  1  MAX_STEPS was reached before the sequence hit 1.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values: all outputs 0; FSM in IDLE. Reset is honoured in any state, including mid-run with a term pending; the pending term is dropped.
- States: IDLE, RUN, DONE.
- IDLE/DONE, start=1:
  - Capture cur<=n_in, steps<=0, peak<=n_in, and clear done and all err_* flags.
  - If n_in==0: go to DONE with err_zero=1; peak=0, steps=0, no terms emitted.
  - Otherwise go to RUN. busy=1 and term_valid=1 on the next cycle (latency 1), with term=n_in.
- start while busy is ignored.
- RUN:
  - term=cur and term_valid=1 continuously. term must hold stable while term_valid & !term_ready.
  - No state change occurs without a handshake.
- On a handshake (term_valid & term_ready), apply the first matching rule:
  1. cur==1: go to DONE. Success, no error flag.
  2. steps==MAX_STEPS: go to DONE with err_limit=1.
  3. Compute next: cur even gives cur>>1; cur odd gives 3*cur+1, computed in WIDTH+2 bits.
  4. If next > 2^WIDTH-1: go to DONE with err_overflow=1. cur, steps and peak are unchanged.
  5. Otherwise cur<=next, steps<=steps+1, peak<=max(peak,next). Stay in RUN; the new term is valid the next cycle.
- Throughput: one term per cycle while term_ready is held high.
- DONE: busy=0, done=1, term_valid=0. steps, peak and err_* hold until the next accepted start. term holds its last value.
- Exactly one err_* flag at most is set per run.
- steps saturates by construction, because MAX_STEPS < 2^CNT_WIDTH is required. The bench asserts this at elaboration.

Optional Feature:
- Macro: HAILSTONE_SHORTCUT_EN.
- Defined: an odd cur steps directly to (3*cur+1)>>1 in one handshake. The skipped even intermediate is never emitted.
  - steps increments by 2 for the shortcut, so the final steps matches the non-shortcut count.
  - The overflow check applies to the shifted result.
  - The limit check becomes steps+2 > MAX_STEPS for an odd cur, still setting err_limit.
  - peak tracks emitted terms only.
- Undefined: one transition per handshake exactly as above. No extra logic is present.

Test Plan:
- Defaults, n_in=6, term_ready=1 → terms 6,3,10,5,16,8,4,2,1 on consecutive cycles; done with steps=8, peak=16, no errors. With HAILSTONE_SHORTCUT_EN → terms 6,3,5,8,4,2,1; steps=8, peak=8.
- n_in=27 → 112 terms, last term 1; steps=111, peak=9232.
- n_in=7, term_ready toggling 1,0,0,1,... → term is stable during the stalls; the sequence 7,22,11,34,17,52,26,13,40,20,10,5,16,8,4,2,1 arrives unaltered; steps=16, peak=52.
- Boundaries:
  - n_in=0 → done next cycle, err_zero=1, no term_valid.
  - n_in=1 → single term 1, steps=0, peak=1.
  - WIDTH=8, n_in=255 → emits 255, then err_overflow=1, steps=0, peak=255.
- MAX_STEPS=5, n_in=7 → emits 7,22,11,34,17,52; on acceptance of 52, err_limit=1 with steps=5, peak=52.
- Mid-run control:
  - reset asserted after the 3rd term of n_in=27 → next cycle all outputs 0, IDLE.
  - A subsequent start with n_in=6 runs correctly.
  - start pulses during RUN are ignored, and the sequence is unchanged.
